pmod_da2_driver: RTL and testbench

PMOD_DA2_DRIVER -- requirements
Module: pmod_da2_driver

---
 rtl/pmod_da2_driver.sv | 189 ++++++++++++++++++
 tb/tb_pmod_da2_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_da2_driver.sv
// Purpose : serialises two 12-bit codes into a 16-bit frame for a dual-channel DAC (PmodDA2).
// Latency : frame starts the cycle after a START rising edge; nSYNC is low for 32*SCLK_HALF cycles.
// Backpres: START edges while BUSY are dropped with an OVERRUN pulse, or (DA2_PENDING_EN) one is queued.
//
// Ports:
//   CLK, RST_N     system clock, synchronous active-low reset
//   START          sample request, rising-edge sensitive
//   DATA1, DATA2   12-bit unsigned channel codes, captured at frame load
//   D1, D2         serial data, MSB first, updated on CLK_OUT rise
//   CLK_OUT        serial clock, idles high
//   nSYNC          active-low frame select
//   DONE           one-cycle pulse as the frame closes
//   BUSY           high while a frame (or the inter-frame gap) is in progress
//   OVERRUN        one-cycle pulse for every discarded START edge
//
// Optional feature: define DA2_PENDING_EN to queue one START edge that arrives while BUSY.

module pmod_da2_driver #(
   parameter int SCLK_HALF = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic [11:0] DATA1,
   input  logic [11:0] DATA2,
   output logic        D1,
   output logic        D2,
   output logic        CLK_OUT,
   output logic        nSYNC,
   output logic        DONE,
   output logic        BUSY,
   output logic        OVERRUN
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [7:0] HALF_M1 = 8'(SCLK_HALF - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;       // cycles elapsed in the current SCLK half-period
   logic [4:0]  tog_q, tog_d;       // toggle index in the frame: even = fall, odd = rise
   logic        fin_q, fin_d;       // frame closed this cycle (DONE cycle), GAP follows
   logic [15:0] sr1_q, sr1_d;
   logic [15:0] sr2_q, sr2_d;
   logic        start_q;
   logic        pend_q, pend_d;
   logic        start_edge;
   logic        load;
   logic        d1_d, d2_d, clk_out_d, nsync_d, done_d, ovr_d, busy_d;

   assign start_edge = START & ~start_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tog_d     = tog_q;
      fin_d     = fin_q;
      sr1_d     = sr1_q;
      sr2_d     = sr2_q;
      pend_d    = pend_q;
      d1_d      = D1;
      d2_d      = D2;
      clk_out_d = CLK_OUT;
      nsync_d   = nSYNC;
      done_d    = 1'b0;
      ovr_d     = 1'b0;
      load      = 1'b0;

      // Edges seen while a frame is active never touch the frame itself.
      if (start_edge && (state_q != IDLE)) begin
`ifdef DA2_PENDING_EN
         if (!pend_q) pend_d = 1'b1;
         else         ovr_d  = 1'b1;
`else
         ovr_d = 1'b1;
`endif
      end

      case (state_q)
         IDLE: begin
            d1_d      = 1'b0;
            d2_d      = 1'b0;
            clk_out_d = 1'b1;
            nsync_d   = 1'b1;
            if (start_edge) load = 1'b1;
         end

         SHIFT: begin
            if (fin_q) begin
               fin_d   = 1'b0;
               state_d = GAP;
            end else if (cnt_q == HALF_M1) begin
               cnt_d = 8'd0;
               tog_d = tog_q + 5'd1;
               if (!tog_q[0]) begin
                  clk_out_d = 1'b0;
               end else if (tog_q == 5'd31) begin
                  // Rise after the 16th fall closes the frame.
                  clk_out_d = 1'b1;
                  nsync_d   = 1'b1;
                  done_d    = 1'b1;
                  d1_d      = 1'b0;
                  d2_d      = 1'b0;
                  fin_d     = 1'b1;
               end else begin
                  clk_out_d = 1'b1;
                  sr1_d     = {sr1_q[14:0], 1'b0};
                  sr2_d     = {sr2_q[14:0], 1'b0};
                  d1_d      = sr1_q[14];
                  d2_d      = sr2_q[14];
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         GAP: begin
`ifdef DA2_PENDING_EN
            // An edge landing in this very cycle is taken as the queued request.
            if (pend_q || start_edge) load = 1'b1;
            else                      state_d = IDLE;
`else
            state_d = IDLE;
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         state_d   = SHIFT;
         sr1_d     = {4'b0000, DATA1};
         sr2_d     = {4'b0000, DATA2};
         d1_d      = sr1_d[15];
         d2_d      = sr2_d[15];
         clk_out_d = 1'b1;
         nsync_d   = 1'b0;
         cnt_d     = 8'd0;
         tog_d     = 5'd0;
         fin_d     = 1'b0;
         pend_d    = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         tog_q   <= 5'd0;
         fin_q   <= 1'b0;
         sr1_q   <= 16'd0;
         sr2_q   <= 16'd0;
         pend_q  <= 1'b0;
         start_q <= 1'b1;   // a START held high through reset is not an edge
         D1      <= 1'b0;
         D2      <= 1'b0;
         CLK_OUT <= 1'b1;
         nSYNC   <= 1'b1;
         DONE    <= 1'b0;
         BUSY    <= 1'b0;
         OVERRUN <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tog_q   <= tog_d;
         fin_q   <= fin_d;
         sr1_q   <= sr1_d;
         sr2_q   <= sr2_d;
         pend_q  <= pend_d;
         start_q <= START;
         D1      <= d1_d;
         D2      <= d2_d;
         CLK_OUT <= clk_out_d;
         nSYNC   <= nsync_d;
         DONE    <= done_d;
         BUSY    <= busy_d;
         OVERRUN <= ovr_d;
      end
   end

endmodule

// File: tb/tb_pmod_da2_driver.sv
// Purpose : scoreboard bench for pmod_da2_driver, SCLK_HALF=1 and SCLK_HALF=4 instances.
// Latency : expected frames are queued at START; the monitor reassembles frames on CLK_OUT falls.
// Backpres: checks OVERRUN / pending behaviour for START edges landing mid-frame.

module tb_pmod_da2_driver;

`ifdef DA2_PENDING_EN
   localparam bit PEND = 1'b1;
`else
   localparam bit PEND = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [1:0]  start;
   logic [11:0] data1, data2;
   logic [1:0]  d1, d2, sclk, nsync, done, busy, ovr;

   int checks = 0;
   int errors = 0;

   pmod_da2_driver #(.SCLK_HALF(1)) dut_h1 (
      .CLK(CLK), .RST_N(RST_N), .START(start[0]), .DATA1(data1), .DATA2(data2),
      .D1(d1[0]), .D2(d2[0]), .CLK_OUT(sclk[0]), .nSYNC(nsync[0]),
      .DONE(done[0]), .BUSY(busy[0]), .OVERRUN(ovr[0])
   );

   pmod_da2_driver #(.SCLK_HALF(4)) dut_h4 (
      .CLK(CLK), .RST_N(RST_N), .START(start[1]), .DATA1(data1), .DATA2(data2),
      .D1(d1[1]), .D2(d2[1]), .CLK_OUT(sclk[1]), .nSYNC(nsync[1]),
      .DONE(done[1]), .BUSY(busy[1]), .OVERRUN(ovr[1])
   );

   always #5 CLK = ~CLK;

   task automatic check(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic int hs(input int g);
      return (g == 0) ? 1 : 4;
   endfunction

   // Scoreboard: expected {DATA1 frame, DATA2 frame} words, one queue per instance.
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   // Monitor state
   logic [15:0] w1[2], w2[2];
   int  nb[2], lowc[2], hic[2], gap_last[2], lastf[2];
   int  fs[2], fd[2], ab[2], dn[2], ov[2];
   bit  ns_p[2] = '{1'b1, 1'b1};
   bit  co_p[2] = '{1'b1, 1'b1};
   int  cycn = 0;

   always @(negedge CLK) begin
      logic [31:0] exp_w;
      cycn++;
      for (int g = 0; g < 2; g++) begin
         if (!nsync[g] && ns_p[g]) begin
            nb[g] = 0; lowc[g] = 0; w1[g] = '0; w2[g] = '0;
            gap_last[g] = hic[g];
            fs[g]++;
         end
         if (!nsync[g] && co_p[g] && !sclk[g]) begin
            w1[g] = {w1[g][14:0], d1[g]};
            w2[g] = {w2[g][14:0], d2[g]};
            if (nb[g] > 0)
               check((cycn - lastf[g]) == 2 * hs(g), "sclk_period", cycn - lastf[g], 2 * hs(g));
            lastf[g] = cycn;
            nb[g]++;
         end
         if (nsync[g] && !ns_p[g]) begin
            hic[g] = 0;
            if (!RST_N) begin
               check(done[g] == 1'b0, "done_on_abort", int'(done[g]), 0);
               ab[g]++;
            end else begin
               check(done[g] == 1'b1, "done_at_nsync_rise", int'(done[g]), 1);
               check(nb[g] == 16, "bit_count", nb[g], 16);
               check(lowc[g] == 32 * hs(g), "nsync_low_len", lowc[g], 32 * hs(g));
               if ((g == 0 ? q0.size() : q1.size()) == 0) begin
                  check(1'b0, "unexpected_frame", int'({w1[g], w2[g]}), 0);
               end else begin
                  exp_w = (g == 0) ? q0.pop_front() : q1.pop_front();
                  check({w1[g], w2[g]} == exp_w, "frame_word", int'({w1[g], w2[g]}), int'(exp_w));
               end
               fd[g]++;
            end
         end else if (done[g]) begin
            check(1'b0, "done_stray", 1, 0);
         end
         if (!nsync[g]) lowc[g]++;
         else           hic[g]++;
         if (nsync[g] && !sclk[g]) check(1'b0, "sclk_idle_high", 0, 1);
         if (done[g]) dn[g]++;
         if (ovr[g])  ov[g]++;
         ns_p[g] = nsync[g];
         co_p[g] = sclk[g];
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_frames(input int g, input int target, input int budget);
      int k = 0;
      while ((fd[g] + ab[g]) < target && k < budget) begin
         cyc(1);
         k++;
      end
      check(k < budget, "frame_timeout", k, budget);
      cyc(2);
   endtask

   // Issue one frame request with START high for 'hold' cycles; data is scrambled after load.
   task automatic frame(input int g, input logic [11:0] a, input logic [11:0] b, input int hold);
      data1 = a;
      data2 = b;
      if (g == 0) q0.push_back({4'b0, a, 4'b0, b});
      else        q1.push_back({4'b0, b == b ? a : a, 4'b0, b});
      start[g] = 1'b1;
      cyc(1);
      data1 = 12'($urandom);
      data2 = 12'($urandom);
      if (hold > 1) cyc(hold - 1);
      start[g] = 1'b0;
      cyc(1);
   endtask

   initial begin
      int tgt, ov0, fs0;
      logic [11:0] a, b, c, d;

      // Reset with START held high throughout and afterwards: no frame may start.
      RST_N = 1'b0;
      start = 2'b11;
      data1 = 12'hFFF;
      data2 = 12'hFFF;
      cyc(2);
      RST_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 0 || i == 9) begin
            check(nsync == 2'b11, "reset_nsync", int'(nsync), 3);
            check(sclk == 2'b11, "reset_sclk", int'(sclk), 3);
            check((d1 | d2) == 2'b00, "reset_data", int'(d1 | d2), 0);
            check((busy | ovr | done) == 2'b00, "reset_flags", int'(busy | ovr | done), 0);
         end
         cyc(1);
      end
      check(fs[0] + fs[1] == 0, "no_frame_after_reset", fs[0] + fs[1], 0);
      start = 2'b00;
      cyc(2);

      // Directed frame, START held for 100 cycles: exactly one frame and one DONE.
      frame(0, 12'hA5C, 12'h3F0, 100);
      wait_frames(0, 1, 200);
      check(fs[0] == 1, "hold_frames", fs[0], 1);
      check(dn[0] == 1, "hold_done", dn[0], 1);

      // Random frames at SCLK_HALF=1.
      for (int i = 0; i < 6; i++) begin
         tgt = fd[0] + ab[0] + 1;
         frame(0, 12'($urandom), 12'($urandom), 1 + int'($urandom_range(0, 3)));
         wait_frames(0, tgt, 200);
         cyc(int'($urandom_range(0, 4)));
      end

      // Extra START edges mid-frame (around bit 7).
      ov0 = ov[0];
      fs0 = fs[0];
      a = 12'($urandom); b = 12'($urandom);
      c = 12'($urandom); d = 12'($urandom);
      tgt = fd[0] + ab[0] + (PEND ? 2 : 1);
      data1 = a; data2 = b;
      q0.push_back({4'b0, a, 4'b0, b});
      start[0] = 1'b1;
      cyc(1);
      start[0] = 1'b0;
      data1 = c; data2 = d;
      cyc(16);
      check(busy[0] == 1'b1, "busy_mid_frame", int'(busy[0]), 1);
      start[0] = 1'b1; cyc(1); start[0] = 1'b0; cyc(1);
      start[0] = 1'b1; cyc(1); start[0] = 1'b0; cyc(1);
      if (PEND) q0.push_back({4'b0, c, 4'b0, d});
      wait_frames(0, tgt, 300);
      check(ov[0] - ov0 == (PEND ? 1 : 2), "overrun_pulses", ov[0] - ov0, PEND ? 1 : 2);
      check(fs[0] - fs0 == (PEND ? 2 : 1), "busy_edge_frames", fs[0] - fs0, PEND ? 2 : 1);
      if (PEND) check(gap_last[0] == 2, "pending_gap", gap_last[0], 2);
      cyc(3);

      // Reset during bit 7: frame aborts, idle outputs on the next cycle, no DONE.
      tgt = dn[0];
      data1 = 12'hFFF; data2 = 12'hFFF;
      start[0] = 1'b1; cyc(1); start[0] = 1'b0;
      cyc(16);
      RST_N = 1'b0;
      cyc(1);
      check(nsync[0] == 1'b1, "abort_nsync", int'(nsync[0]), 1);
      check(sclk[0] == 1'b1, "abort_sclk", int'(sclk[0]), 1);
      check({d1[0], d2[0]} == 2'b00, "abort_data", int'({d1[0], d2[0]}), 0);
      check(busy[0] == 1'b0, "abort_busy", int'(busy[0]), 0);
      cyc(1);
      RST_N = 1'b1;
      cyc(4);
      check(ab[0] == 1, "abort_count", ab[0], 1);
      check(dn[0] == tgt, "abort_no_done", dn[0], tgt);

      // Random frames at SCLK_HALF=4.
      for (int i = 0; i < 3; i++) begin
         tgt = fd[1] + ab[1] + 1;
         frame(1, 12'($urandom), 12'($urandom), 1);
         wait_frames(1, tgt, 400);
      end

      cyc(4);
      check(q0.size() == 0, "q0_drained", q0.size(), 0);
      check(q1.size() == 0, "q1_drained", q1.size(), 0);
      check(dn[0] == fd[0], "done_count_h1", dn[0], fd[0]);
      check(dn[1] == 3, "done_count_h4", dn[1], 3);
      check(ov[1] == 0, "no_overrun_h4", ov[1], 0);
      check(ov[0] == (PEND ? 1 : 2), "overrun_total_h1", ov[0], PEND ? 1 : 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
